// File: rtl/seq_det_pkg.sv
// Shared types and constants for the configurable serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int MAX_LEN_DEF = 8;
  localparam int LEN_W       = 4;

endpackage

// File: rtl/seq_det_core.sv
// History shift register, fill counter and length-masked pattern compare.
// SEQ_DET_OVERLAP_EN: keep history after a hit so matches may overlap.
module seq_det_core
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic               clk,
  input  logic               en,
  input  logic               clr,
  input  logic               bit_valid,
  input  logic               bit_in,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               hit
);

  logic [MAX_LEN-1:0] history;
  logic [MAX_LEN-1:0] history_nxt;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   fill_nxt;
  logic               adv;

  // Compare against the post-shift history so a hit is known in the same cycle as its last bit.
  always_comb begin
    adv         = en & bit_valid;
    history_nxt = {history[MAX_LEN-2:0], bit_in};
    fill_nxt    = (fill >= LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : fill + 1'b1;
    mask        = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
    hit = adv && (fill_nxt >= len) && (((history_nxt ^ pattern) & mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      history <= '0;
      fill    <= '0;
    end else if (adv) begin
`ifdef SEQ_DET_OVERLAP_EN
      history <= history_nxt;
      fill    <= fill_nxt;
`else
      if (hit) begin
        history <= '0;
        fill    <= '0;
      end else begin
        history <= history_nxt;
        fill    <= fill_nxt;
      end
`endif
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run-time controller: config registers, IDLE/RUN/DONE FSM and saturating match counter.
// Optional SEQ_DET_OVERLAP_EN (see seq_det_core) enables overlapping matches.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               stop,
  input  logic               bit_valid,
  input  logic               bit_in,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  state_t             state;
  state_t             state_nxt;
  logic [MAX_LEN-1:0] pattern_r;
  logic [LEN_W-1:0]   len_r;
  logic [CNT_W-1:0]   target_r;
  logic [CNT_W-1:0]   cnt_inc;
  logic               cfg_ok;
  logic               arm;
  logic               hit;
  logic               tgt_hit;
  logic               core_clr;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_nxt = state;
    arm       = 1'b0;
    cfg_ok    = cfg_we && (state != RUN) && (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    cnt_inc   = sat_inc(match_count);
    tgt_hit   = hit && (target_r != '0) && (cnt_inc == target_r);
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          arm       = 1'b1;
        end
      end
      RUN: begin
        if (stop) state_nxt = IDLE;
        else if (tgt_hit) state_nxt = DONE;
      end
      DONE: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (start) begin
          state_nxt = RUN;
          arm       = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Arming always starts from an empty history, so stale partial matches never carry over.
  assign core_clr = rst_n | arm;

  seq_det_core #(
    .MAX_LEN (MAX_LEN)
  ) u_core (
    .clk       (clk),
    .en        (state == RUN),
    .clr       (core_clr),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .pattern   (pattern_r),
    .len       (len_r),
    .hit       (hit)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state       <= IDLE;
      pattern_r   <= '0;
      len_r       <= LEN_W'(1);
      target_r    <= '0;
      match       <= 1'b0;
      match_count <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      busy    <= (state_nxt == RUN);
      done    <= (state_nxt == DONE);
      cfg_err <= cfg_we && !cfg_ok;
      match   <= hit;
      if (cfg_ok) begin
        pattern_r <= cfg_pattern;
        len_r     <= cfg_len;
        target_r  <= cfg_target;
      end
      if (arm) match_count <= '0;
      else if (hit) match_count <= cnt_inc;
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed self-checking bench for seq_det_ctrl; expectations follow SEQ_DET_OVERLAP_EN.
module tb_seq_det_ctrl;

`ifdef SEQ_DET_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic [7:0] cfg_target;
  logic       start;
  logic       stop;
  logic       bit_valid;
  logic       bit_in;
  logic       match;
  logic [7:0] match_count;
  logic       busy;
  logic       done;
  logic       cfg_err;

  int n_pass  = 0;
  int n_total = 0;
  int nm      = 0;

  seq_det_ctrl #(
    .MAX_LEN (8),
    .CNT_W   (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_target  (cfg_target),
    .start       (start),
    .stop        (stop),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .match       (match),
    .match_count (match_count),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    if (match === 1'b1) nm++;
  endtask

  task automatic write_cfg(input logic [7:0] p, input logic [3:0] l, input logic [7:0] t);
    cfg_we      = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_target  = t;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    n_total++; if (match !== 1'b0) $display("FAIL reset_match: got %b want 0", match); else n_pass++;
    n_total++; if (match_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", match_count); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_total++; if (cfg_err !== 1'b0) $display("FAIL reset_cfg_err: got %b want 0", cfg_err); else n_pass++;
    rst_n = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    write_cfg(8'h0B, 4'd4, 8'd0);
    n_total++; if (cfg_err !== 1'b0) $display("FAIL basic_cfg_err: got %b want 0", cfg_err); else n_pass++;
    pulse_start();
    n_total++; if (busy !== 1'b1) $display("FAIL basic_busy_start: got %b want 1", busy); else n_pass++;
    nm = 0;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    n_total++; if (nm !== 0) $display("FAIL basic_early_match: got %0d want 0", nm); else n_pass++;
    send_bit(1'b1);
    n_total++; if (match !== 1'b1) $display("FAIL basic_match_pulse: got %b want 1", match); else n_pass++;
    tick();
    n_total++; if (match !== 1'b0) $display("FAIL basic_match_one_cycle: got %b want 0", match); else n_pass++;
    n_total++; if (match_count !== 8'd1) $display("FAIL basic_count: got %0d want 1", match_count); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL basic_busy_hold: got %b want 1", busy); else n_pass++;
  endtask

  task automatic test_overlap();
    logic [6:0] s;
    int exp_m;
    s     = 7'b1011011;
    exp_m = OVL ? 2 : 1;
    pulse_stop();
    n_total++; if (busy !== 1'b0) $display("FAIL ovl_stop_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (match_count !== 8'd1) $display("FAIL ovl_stop_count_kept: got %0d want 1", match_count); else n_pass++;
    pulse_start();
    n_total++; if (match_count !== 8'd0) $display("FAIL ovl_start_clear: got %0d want 0", match_count); else n_pass++;
    nm = 0;
    for (int i = 6; i >= 0; i--) send_bit(s[i]);
    n_total++; if (nm !== exp_m) $display("FAIL ovl_matches: got %0d want %0d", nm, exp_m); else n_pass++;
    n_total++; if (match_count !== 8'(exp_m)) $display("FAIL ovl_count: got %0d want %0d", match_count, exp_m); else n_pass++;
    pulse_stop();
  endtask

  task automatic test_target();
    int last;
    int exp_last;
    last     = 0;
    exp_last = OVL ? 4 : 6;
    write_cfg(8'h03, 4'd2, 8'd3);
    pulse_start();
    nm = 0;
    for (int i = 1; i <= 8; i++) begin
      send_bit(1'b1);
      if (match === 1'b1) last = i;
    end
    n_total++; if (nm !== 3) $display("FAIL tgt_matches: got %0d want 3", nm); else n_pass++;
    n_total++; if (last !== exp_last) $display("FAIL tgt_last_bit: got %0d want %0d", last, exp_last); else n_pass++;
    n_total++; if (done !== 1'b1) $display("FAIL tgt_done: got %b want 1", done); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL tgt_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (match_count !== 8'd3) $display("FAIL tgt_count: got %0d want 3", match_count); else n_pass++;
  endtask

  task automatic test_cfg_reject();
    write_cfg(8'hFF, 4'd0, 8'd0);
    n_total++; if (cfg_err !== 1'b1) $display("FAIL rej_len0_err: got %b want 1", cfg_err); else n_pass++;
    tick();
    n_total++; if (cfg_err !== 1'b0) $display("FAIL rej_err_one_cycle: got %b want 0", cfg_err); else n_pass++;
    write_cfg(8'hFF, 4'd9, 8'd0);
    n_total++; if (cfg_err !== 1'b1) $display("FAIL rej_len9_err: got %b want 1", cfg_err); else n_pass++;
    pulse_start();
    n_total++; if (busy !== 1'b1) $display("FAIL rej_restart_busy: got %b want 1", busy); else n_pass++;
    nm = 0;
    send_bit(1'b1);
    send_bit(1'b1);
    n_total++; if (nm !== 1) $display("FAIL rej_old_pattern: got %0d want 1", nm); else n_pass++;
    write_cfg(8'h0B, 4'd4, 8'd0);
    n_total++; if (cfg_err !== 1'b1) $display("FAIL rej_run_write_err: got %b want 1", cfg_err); else n_pass++;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    n_total++; if (nm !== 2) $display("FAIL rej_pattern_kept: got %0d want 2", nm); else n_pass++;
    n_total++; if (match_count !== 8'd2) $display("FAIL rej_count: got %0d want 2", match_count); else n_pass++;
  endtask

  task automatic test_start_stop();
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    n_total++; if (busy !== 1'b0) $display("FAIL ss_stop_wins: got %b want 0", busy); else n_pass++;
    n_total++; if (match_count !== 8'd2) $display("FAIL ss_count_kept: got %0d want 2", match_count); else n_pass++;
    nm = 0;
    send_bit(1'b1);
    tick();
    send_bit(1'b1);
    n_total++; if (nm !== 0) $display("FAIL ss_idle_no_match: got %0d want 0", nm); else n_pass++;
    cfg_we      = 1'b1;
    cfg_pattern = 8'h0B;
    cfg_len     = 4'd4;
    cfg_target  = 8'd0;
    start       = 1'b1;
    tick();
    cfg_we = 1'b0;
    start  = 1'b0;
    n_total++; if (busy !== 1'b1) $display("FAIL ss_cfg_start_busy: got %b want 1", busy); else n_pass++;
    n_total++; if (match_count !== 8'd0) $display("FAIL ss_cfg_start_clear: got %0d want 0", match_count); else n_pass++;
    nm = 0;
    send_bit(1'b1);
    tick();
    send_bit(1'b0);
    tick();
    tick();
    send_bit(1'b1);
    n_total++; if (nm !== 0) $display("FAIL ss_gap_early: got %0d want 0", nm); else n_pass++;
    send_bit(1'b1);
    n_total++; if (match !== 1'b1) $display("FAIL ss_gap_match: got %b want 1", match); else n_pass++;
    n_total++; if (match_count !== 8'd1) $display("FAIL ss_gap_count: got %0d want 1", match_count); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rst_n = 1'b1;
    tick();
    n_total++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL rmid_done: got %b want 0", done); else n_pass++;
    n_total++; if (match !== 1'b0) $display("FAIL rmid_match: got %b want 0", match); else n_pass++;
    n_total++; if (match_count !== 8'd0) $display("FAIL rmid_count: got %0d want 0", match_count); else n_pass++;
    rst_n = 1'b0;
    write_cfg(8'h0B, 4'd4, 8'd0);
    pulse_start();
    nm = 0;
    send_bit(1'b1);
    tick();
    n_total++; if (nm !== 0) $display("FAIL rmid_fresh_history: got %0d want 0", nm); else n_pass++;
    n_total++; if (match_count !== 8'd0) $display("FAIL rmid_fresh_count: got %0d want 0", match_count); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL rmid_restart_busy: got %b want 1", busy); else n_pass++;
  endtask

  initial begin
    rst_n       = 1'b1;
    cfg_we      = 1'b0;
    cfg_pattern = 8'h00;
    cfg_len     = 4'd1;
    cfg_target  = 8'd0;
    start       = 1'b0;
    stop        = 1'b0;
    bit_valid   = 1'b0;
    bit_in      = 1'b0;
    test_reset();
    test_basic();
    test_overlap();
    test_target();
    test_cfg_reject();
    test_start_stop();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Run-time controller for the team's serial pattern detector. It holds a programmable pattern of 1 to 8 bits, arms and disarms detection, and qualifies the incoming serial bit stream. It counts matches and stops on its own once a programmed match target is reached. The block sits between the TinyTapeout top-level pins and the detector datapath, and replaces the hard-wired "1011" detector with a configurable one.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (pattern register width)
CNT_W, 8, width of the match counter and of the match target

Ports:
clk  input  1  clock; all logic on the rising edge
rst_n  input  1  synchronous, active-high reset (1 = reset), sampled on the rising edge of clk
cfg_we  input  1  configuration write strobe
cfg_pattern  input  MAX_LEN  pattern; bit [cfg_len-1] is the first bit expected on the serial input
cfg_len  input  4  pattern length; legal values 1..MAX_LEN
cfg_target  input  CNT_W  stop after this many matches; 0 = run until stop
start  input  1  arm detection (single-cycle pulse)
stop  input  1  disarm detection (single-cycle pulse)
bit_valid  input  1  bit_in is sampled this cycle
bit_in  input  1  serial data bit
match  output  1  one-cycle pulse per detected match
match_count  output  CNT_W  number of matches since the last start; saturates at all-ones
busy  output  1  high in RUN
done  output  1  high in DONE
cfg_err  output  1  one-cycle pulse when a configuration write is rejected

Behaviour:
- Reset: state=IDLE; pattern=0; len=1; target=0; history=0; fill=0; match=0; match_count=0; busy=0; done=0; cfg_err=0. Reset overrides every other input, including in mid-run.
- States: IDLE, RUN, DONE. Outputs are registered: busy=(state==RUN), done=(state==DONE).
- IDLE:
  - start -> RUN; clear match_count, history and fill.
  - bit_valid is ignored.
- RUN:
  - stop -> IDLE; match_count keeps its value.
  - When start and stop arrive in the same cycle, stop wins.
  - A start while already in RUN is ignored.
- DONE:
  - start -> RUN, with the same clears as from IDLE.
  - stop -> IDLE.
  - bit_valid is ignored.
- Config write:
  - Accepted only in IDLE or DONE, and only when 1 <= cfg_len <= MAX_LEN.
  - An accepted write loads pattern, len and target on that edge.
  - Otherwise the write is dropped and cfg_err pulses the next cycle.
  - When cfg_we and start arrive in the same cycle in IDLE, the config loads first and the run uses the new values.
- Detection (RUN only, when bit_valid=1):
  - history <= {history[MAX_LEN-2:0], bit_in}.
  - fill <= min(fill+1, MAX_LEN).
  - The comparison uses the updated history and fill.
  - Hit condition: (fill >= len) and history[len-1:0] == pattern[len-1:0].
  - On a hit, match pulses in the cycle after the completing bit (1-cycle latency), and match_count increments with saturation.
  - Cycles with bit_valid=0 do not advance history and never produce a hit.
- Target:
  - If target != 0 and the increment makes match_count == target, the next state is DONE on the same edge that registers match.
  - Bits arriving after that edge are ignored.
- Stop mid-pattern: any partial match is lost; the next start begins from an empty history.

Optional Feature:
Macro SEQ_DET_OVERLAP_EN.
- Defined: overlapping matches are allowed; history and fill are kept after a hit.
- Undefined: on a hit, history and fill are cleared in the same edge, so the next match needs len fresh bits.

Decomposition:
- Package seq_det_pkg: state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10), the MAX_LEN default, and the LEN_W=4 constant.
- Sub-module seq_det_core: history shift register, fill counter and masked compare. Interface: en, clr, bit_valid, bit_in, pattern, len -> hit. The FSM, counter and config registers live in seq_det_ctrl.

Test Plan:
- Basic "1011": cfg pattern=8'h0B, len=4, target=0; start; bits 1,0,1,1 -> match pulses once, 1 cycle after the 4th valid bit; match_count=1; busy stays 1.
- Overlap: same config, stream 1,0,1,1,0,1,1 -> with SEQ_DET_OVERLAP_EN: 2 matches, count=2. Without it: 1 match, count=1.
- Target stop: len=2, pattern=2'b11, target=3; stream of eight 1s -> with overlap, matches on bits 2, 3 and 4, then done=1, busy=0, count=3; bits 5-8 are ignored.
- Config rejection: cfg_we with len=0, then len=9, then a legal write during RUN -> cfg_err pulses each time; pattern and len are unchanged.
- Start/stop priority: start=stop=1 in RUN -> IDLE with count retained. Then feed bits with bit_valid gaps -> no match while in IDLE; gaps in RUN do not break a pattern.
- Reset mid-run: assert rst_n=1 after "101" -> all outputs 0 on the next edge. After reset, start followed by "1" gives no match (history cleared).
